// File: rtl/gather_writeback_collector.sv
// Gather-load writeback collector: buffers per-lane results arriving in any order
// and issues one masked vector writeback. Optional lane error reporting: GATHER_LANE_CHECK_EN.
module gather_wb_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  input  logic         wb_ld_i,
  output logic [W-1:0] wb_o
);
  logic [W-1:0] buf_q, buf_d, wb_q;

  always_comb begin
    buf_d = buf_q;
    if (clr_i)     buf_d = '0;
    else if (we_i) buf_d = d_i;
  end

  // Writeback copy loads from buf_d so the lane landing on the completing edge is included
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
      wb_q  <= '0;
    end else begin
      buf_q <= buf_d;
      if (wb_ld_i) wb_q <= buf_d;
    end
  end

  assign wb_o = wb_q;
endmodule

module gather_writeback_collector #(
  parameter int LANES         = 16,
  parameter int LANE_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 7,
  localparam int IW           = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [REG_IDX_WIDTH-1:0]    start_reg,
  input  logic [LANES-1:0]            start_mask,
  input  logic                        lane_valid,
  output logic                        lane_ready,
  input  logic [IW-1:0]               lane_idx,
  input  logic [LANE_WIDTH-1:0]       lane_value,
  input  logic                        abort,
  output logic                        busy,
`ifdef GATHER_LANE_CHECK_EN
  output logic                        lane_error,
  output logic [IW-1:0]               error_lane_idx,
`endif
  output logic [REG_IDX_WIDTH-1:0]    wb_writeback_reg,
  output logic [LANES*LANE_WIDTH-1:0] wb_writeback_value,
  output logic [LANES-1:0]            wb_writeback_mask,
  output logic                        wb_enable_vector_writeback
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WB} state_t;

  state_t                       state_q, state_d;
  logic [REG_IDX_WIDTH-1:0]     reg_q, reg_d, wb_reg_q;
  logic [LANES-1:0]             mask_q, mask_d, pend_q, pend_d, wb_mask_q;
  logic                         start_ready_q, lane_ready_q, busy_q, wb_en_q;
  logic                         buf_clr, lane_hit, accept;
  logic [LANES-1:0]             lane_we;
  logic [LANES-1:0][LANE_WIDTH-1:0] wb_val;

  assign accept = lane_ready_q && lane_valid;

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    buf_clr  = 1'b0;
    lane_hit = 1'b0;
    lane_we  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          reg_d   = start_reg;
          mask_d  = start_mask;
          pend_d  = start_mask;
          buf_clr = 1'b1;
          if (start_mask != '0) state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && mask_q[lane_idx]) begin
          lane_hit         = 1'b1;
          lane_we[lane_idx] = 1'b1;
          pend_d[lane_idx] = 1'b0;
          if (pend_d == '0) state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      gather_wb_lane #(.W(LANE_WIDTH)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (buf_clr),
        .we_i    (lane_we[g]),
        .d_i     (lane_value),
        .wb_ld_i (state_d == S_WB),
        .wb_o    (wb_val[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      reg_q         <= '0;
      mask_q        <= '0;
      pend_q        <= '0;
      start_ready_q <= 1'b1;
      lane_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_reg_q      <= '0;
      wb_mask_q     <= '0;
    end else begin
      state_q       <= state_d;
      reg_q         <= reg_d;
      mask_q        <= mask_d;
      pend_q        <= pend_d;
      start_ready_q <= (state_d == S_IDLE);
      lane_ready_q  <= (state_d == S_COLLECT);
      busy_q        <= (state_d != S_IDLE);
      wb_en_q       <= (state_d == S_WB);
      if (state_d == S_WB) begin
        wb_reg_q  <= reg_q;
        wb_mask_q <= mask_q;
      end
    end
  end

`ifdef GATHER_LANE_CHECK_EN
  logic          lane_err_q;
  logic [IW-1:0] err_idx_q;
  logic          lane_bad;

  assign lane_bad = accept && !abort && !(mask_q[lane_idx] && pend_q[lane_idx]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_err_q <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      lane_err_q <= lane_bad;
      if (lane_bad) err_idx_q <= lane_idx;
    end
  end

  assign lane_error     = lane_err_q;
  assign error_lane_idx = err_idx_q;
`endif

  assign start_ready                = start_ready_q;
  assign lane_ready                 = lane_ready_q;
  assign busy                       = busy_q;
  assign wb_enable_vector_writeback = wb_en_q;
  assign wb_writeback_reg           = wb_reg_q;
  assign wb_writeback_mask          = wb_mask_q;
  assign wb_writeback_value         = wb_val;
endmodule

// File: doc/gather_writeback_collector.md
Name: gather_writeback_collector

Overview:
- Write-side producer for the vector register file: collects per-lane gather-load results arriving one lane per cycle, in any order, from the memory pipeline.
- Issues a single masked vector writeback once every requested lane has arrived.
- Drives the wb_writeback_reg / wb_writeback_value / wb_writeback_mask / wb_enable_vector_writeback port group of the vector register file directly.

Parameters:
- LANES, 16, number of vector lanes; power of two.
- LANE_WIDTH, 32, bits per lane.
- REG_IDX_WIDTH, 7, register index width (strand ID plus register number).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  request to begin a gather.
- start_ready  out  1  collector can accept a start.
- start_reg  in  REG_IDX_WIDTH  destination vector register.
- start_mask  in  LANES  lanes to be gathered.
- lane_valid  in  1  lane result present.
- lane_ready  out  1  collector accepts lane results.
- lane_idx  in  log2(LANES)  lane number of the result.
- lane_value  in  LANE_WIDTH  loaded data.
- abort  in  1  rollback; cancel the gather in progress.
- busy  out  1  gather in progress (COLLECT or WRITEBACK).
- wb_writeback_reg  out  REG_IDX_WIDTH  register to write.
- wb_writeback_value  out  LANES*LANE_WIDTH  lane N at bits [N*LANE_WIDTH +: LANE_WIDTH].
- wb_writeback_mask  out  LANES  lanes to update.
- wb_enable_vector_writeback  out  1  one-cycle writeback strobe.

Behaviour:
- Reset: asynchronous on reset low. State goes to IDLE. All outputs are 0 except start_ready, which is 1. The value buffer and pending mask are cleared.
- Reset mid-gather: the gather is discarded and no writeback is issued.
- States: IDLE, COLLECT, WRITEBACK.
- All wb_* outputs, start_ready, lane_ready and busy are registered outputs.
- start_ready = 1 only in IDLE. lane_ready = 1 only in COLLECT.
- IDLE, on start_valid:
  - Latch start_reg and start_mask.
  - Set pending = start_mask.
  - Clear the value buffer to 0.
  - If start_mask == 0: accept the start, stay in IDLE, issue no writeback.
  - Otherwise go to COLLECT.
- COLLECT, on lane_valid:
  - Write lane_value into buffer[lane_idx] and clear pending[lane_idx].
  - A duplicate lane (pending bit already 0 but bit set in start_mask) overwrites the stored value; the pending count is unchanged.
  - A lane not in start_mask is discarded; the buffer is unchanged.
  - When the accepted lane clears the last pending bit, go to WRITEBACK.
- WRITEBACK: held for exactly one cycle.
  - wb_enable_vector_writeback = 1, wb_writeback_reg = latched reg, wb_writeback_mask = latched start_mask, wb_writeback_value = buffer.
  - Unmasked lanes read 0.
  - The next state is IDLE.
- Latency: last lane accepted at edge N; strobe high during cycle N+1; start_ready returns to 1 in cycle N+2.
- No backpressure from the register file: its write port always accepts.
- wb_enable_vector_writeback is 0 in every state other than WRITEBACK. The wb_writeback_reg, wb_writeback_mask and wb_writeback_value outputs hold their last values.
- abort:
  - In COLLECT: return to IDLE, no writeback.
  - Has priority over a simultaneous lane_valid that completes the gather.
  - Also cancels a WRITEBACK registered for the next cycle if it is asserted on the completing edge: the strobe never rises.
  - Ignored in IDLE. A start_valid coincident with abort in IDLE is accepted normally.
- lane_valid while not in COLLECT: ignored, because lane_ready = 0.

Optional Feature:
- Macro: GATHER_LANE_CHECK_EN.
- When defined:
  - Adds output lane_error (1 bit, registered, reset 0).
  - lane_error pulses for one cycle after any accepted lane that is out of mask or a duplicate.
  - Adds output error_lane_idx, which holds that lane index.
- When undefined: neither port exists; out-of-mask and duplicate lanes are silently handled as above.

Test Plan:
- Start reg 0x23, mask 0x0005; lanes 2 (0xBBBB0002) then 0 (0xAAAA0001) -> one strobe one cycle after lane 0, reg 0x23, mask 0x0005, value lane0 = 0xAAAA0001, lane2 = 0xBBBB0002, other lanes 0; start_ready = 1 two cycles after the last lane.
- Mask 0xFFFF, 16 lanes in reverse order, value = 0x100 + idx -> single strobe, every lane correct, busy low after strobe.
- Mask 0x0003; lane 1 = 0x11, lane 1 = 0x22, lane 5 = 0x55, lane 0 = 0x00 -> strobe after lane 0, lane1 = 0x22, lane 5 = 0, mask 0x0003; with GATHER_LANE_CHECK_EN, lane_error pulses twice (idx 1, then 5).
- Mask 0x000F; two lanes, then abort coincident with the third; then new start, mask 0x0001, lane 0 -> no strobe for the first gather; second gather writes only lane 0, with stale lanes reading 0.
- Start with mask 0x0000 -> no strobe, start_ready stays 1, busy stays 0.
- Reset low during COLLECT after 3 of 4 lanes -> outputs 0, start_ready = 1, no strobe after reset release; lane_valid is ignored.
